// File: rtl/io_hub_fx.sv
// io_hub_fx: handshake hub between the fixed-point core's I/O strobes and its
// peripherals. Every input and output channel gets a valid/ready handshake.
// The output side has a one-word holding register. The core is stalled while a
// peripheral is not ready. An optional wait limit means a dead peripheral
// raises a sticky flag instead of hanging the core.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_in, addr_in, io_in     core input request, channel select, registered word
//   out_en, addr_out, data_out core output strobe, channel select, word
//   stall                      core must hold its state this cycle
//   ch_in_data/valid/ready     peripheral input channels (ready is one-hot)
//   ch_out_data/valid/ready    peripheral output channels (valid is one-hot)
//   err_clr                    clears the sticky flags
//   tmo_in, tmo_out, bad_addr  sticky: input timeout, output timeout, bad channel
//
// state    | meaning
// IDLE     | no input transfer pending; a request is served the same cycle
// WAIT_IN  | request latched, waiting for ch_in_valid of the latched channel
// EMPTY    | output holding register free
// FULL     | output holding register presents a word until its channel is ready
module io_hub_fx #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int TMOUT  = 255,
  localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int TW  = (TMOUT > 0) ? $clog2(TMOUT + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [AWI-1:0]           addr_in,
  output logic [NUBITS-1:0]        io_in,
  input  logic                     out_en,
  input  logic [AWO-1:0]           addr_out,
  input  logic [NUBITS-1:0]        data_out,
  output logic                     stall,
  input  logic [NUIOIN*NUBITS-1:0] ch_in_data,
  input  logic [NUIOIN-1:0]        ch_in_valid,
  output logic [NUIOIN-1:0]        ch_in_ready,
  output logic [NUBITS-1:0]        ch_out_data,
  output logic [NUIOOU-1:0]        ch_out_valid,
  input  logic [NUIOOU-1:0]        ch_out_ready,
  input  logic                     err_clr,
  output logic                     tmo_in,
  output logic                     tmo_out,
  output logic                     bad_addr
);

  typedef enum logic {IDLE, WAIT_IN} in_state_e;
  typedef enum logic {EMPTY, FULL}   out_state_e;

  localparam logic [AWI:0] NIN_L = (AWI + 1)'(NUIOIN);
  localparam logic [AWO:0] NOU_L = (AWO + 1)'(NUIOOU);

  in_state_e         in_state_q, in_state_d;
  logic [AWI-1:0]    in_ch_q, in_ch_d;
  logic [TW-1:0]     in_cnt_q, in_cnt_d;
  logic [NUBITS-1:0] io_in_q, io_in_d;
  out_state_e        out_state_q, out_state_d;
  logic [AWO-1:0]    out_ch_q, out_ch_d;
  logic [NUBITS-1:0] out_data_q, out_data_d;
  logic [TW-1:0]     out_cnt_q, out_cnt_d;
  logic              tmo_in_q, tmo_in_d;
  logic              tmo_out_q, tmo_out_d;
  logic              bad_addr_q, bad_addr_d;

  logic              addr_in_ok, addr_out_ok;
  logic [AWI-1:0]    sel_ch;
  logic [NUBITS-1:0] sel_word;
  logic              sel_valid;
  logic              in_hs, in_stall, in_tmo_set, in_bad_set, in_expired;
  logic              out_ready_sel, drain, out_stall, out_tmo_set, out_bad_set, out_expired;

  assign addr_in_ok  = {1'b0, addr_in} < NIN_L;
  assign addr_out_ok = {1'b0, addr_out} < NOU_L;

  // While waiting, the latched channel is served and the core's address is ignored.
  assign sel_ch = (in_state_q == WAIT_IN) ? in_ch_q : addr_in;

  // Mux over real channels only, so a non-power-of-two channel count never
  // indexes past the end of the peripheral buses.
  always_comb begin
    sel_word      = '0;
    sel_valid     = 1'b0;
    out_ready_sel = 1'b0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (sel_ch == AWI'(k)) begin
        sel_word  = ch_in_data[k*NUBITS +: NUBITS];
        sel_valid = ch_in_valid[k];
      end
    end
    for (int k = 0; k < NUIOOU; k++) begin
      if (out_ch_q == AWO'(k)) out_ready_sel = ch_out_ready[k];
    end
  end

  // The request cycle counts as the first stalled cycle, so the wait ends
  // after exactly TMOUT stalled cycles.
  assign in_expired  = (TMOUT > 0) && (int'(in_cnt_q) + 1 == TMOUT);
  assign out_expired = (TMOUT > 0) && (int'(out_cnt_q) == TMOUT);

  always_comb begin
    in_state_d = in_state_q;
    in_ch_d    = in_ch_q;
    in_cnt_d   = in_cnt_q;
    io_in_d    = io_in_q;
    in_hs      = 1'b0;
    in_stall   = 1'b0;
    in_tmo_set = 1'b0;
    in_bad_set = 1'b0;
    if (in_state_q == IDLE) begin
      if (req_in) begin
        if (!addr_in_ok) begin
          io_in_d    = '0;
          in_bad_set = 1'b1;
        end else if (sel_valid) begin
          in_hs   = 1'b1;
          io_in_d = sel_word;
        end else begin
          in_stall   = 1'b1;
          in_ch_d    = addr_in;
          in_cnt_d   = '0;
          in_state_d = WAIT_IN;
        end
      end
    end else begin
      if (sel_valid) begin
        in_hs      = 1'b1;
        io_in_d    = sel_word;
        in_state_d = IDLE;
      end else if (in_expired) begin
        io_in_d    = '0;
        in_tmo_set = 1'b1;
        in_state_d = IDLE;
      end else begin
        in_stall = 1'b1;
        if (in_cnt_q != '1) in_cnt_d = in_cnt_q + 1'b1;
      end
    end
    for (int k = 0; k < NUIOIN; k++) ch_in_ready[k] = in_hs && (sel_ch == AWI'(k));
  end

  assign drain = (out_state_q == FULL) && out_ready_sel;

  always_comb begin
    out_state_d = drain ? EMPTY : out_state_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_cnt_d   = '0;
    out_stall   = 1'b0;
    out_tmo_set = 1'b0;
    out_bad_set = 1'b0;
    if (out_en) begin
      if (!addr_out_ok) begin
        out_bad_set = 1'b1;
      end else if (out_state_q == EMPTY || drain || out_expired) begin
        // On expiry the undelivered word is overwritten by the new one.
        out_tmo_set = (out_state_q == FULL) && !drain;
        out_state_d = FULL;
        out_ch_d    = addr_out;
        out_data_d  = data_out;
      end else begin
        out_stall = 1'b1;
        out_cnt_d = (out_cnt_q != '1) ? out_cnt_q + 1'b1 : out_cnt_q;
      end
    end
    for (int k = 0; k < NUIOOU; k++)
      ch_out_valid[k] = (out_state_q == FULL) && (out_ch_q == AWO'(k));
  end

  // A set event in the same cycle wins over err_clr.
  assign tmo_in_d   = in_tmo_set | (tmo_in_q & ~err_clr);
  assign tmo_out_d  = out_tmo_set | (tmo_out_q & ~err_clr);
  assign bad_addr_d = in_bad_set | out_bad_set | (bad_addr_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q  <= IDLE;
      in_ch_q     <= '0;
      in_cnt_q    <= '0;
      io_in_q     <= '0;
      out_state_q <= EMPTY;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      tmo_in_q    <= 1'b0;
      tmo_out_q   <= 1'b0;
      bad_addr_q  <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      in_ch_q     <= in_ch_d;
      in_cnt_q    <= in_cnt_d;
      io_in_q     <= io_in_d;
      out_state_q <= out_state_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      tmo_in_q    <= tmo_in_d;
      tmo_out_q   <= tmo_out_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign stall       = in_stall | out_stall;
  assign io_in       = io_in_q;
  assign ch_out_data = out_data_q;
  assign tmo_in      = tmo_in_q;
  assign tmo_out     = tmo_out_q;
  assign bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_io_hub_fx.sv
module tb_io_hub_fx;
  localparam int W   = 32;
  localparam int NIN = 6;
  localparam int NOU = 7;
  localparam int TM  = 10;

  logic             clk, rst;
  logic             req_in, out_en, err_clr, stall;
  logic [2:0]       addr_in, addr_out;
  logic [W-1:0]     io_in, data_out, ch_out_data;
  logic [NIN*W-1:0] ch_in_data;
  logic [NIN-1:0]   ch_in_valid, ch_in_ready;
  logic [NOU-1:0]   ch_out_valid, ch_out_ready;
  logic             tmo_in, tmo_out, bad_addr;

  io_hub_fx #(.NUBITS(W), .NUIOIN(NIN), .NUIOOU(NOU), .TMOUT(TM)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out), .stall(stall),
    .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
    .ch_out_data(ch_out_data), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
    .err_clr(err_clr), .tmo_in(tmo_in), .tmo_out(tmo_out), .bad_addr(bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: pending input request, holding register, sticky flags
  bit           m_wait = 0;
  int           m_ich = 0, m_iel = 0;
  logic [W-1:0] m_io = '0;
  bit           m_full = 0;
  int           m_och = 0, m_oblk = 0;
  logic [W-1:0] m_word = '0;
  bit           m_ti = 0, m_to = 0, m_bad = 0;
  bit           m_stall = 0;

  // DUT outputs seen in the most recent cycle, for scenario-level checks
  logic             obs_stall;
  logic [NIN-1:0]   obs_rdy;
  logic [NOU-1:0]   obs_vld;
  logic [W-1:0]     obs_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare this cycle's outputs with the model at the
  // negative edge, then advance the model across the rising edge.
  task automatic step();
    logic [NIN-1:0] e_rdy;
    logic [NOU-1:0] e_vld;
    bit             e_ist, e_ost, n_wait, n_full, s_bad, s_ti, s_to, drain;
    int             n_ich, n_iel, n_och, n_oblk, a;
    logic [W-1:0]   n_io, n_word;
    @(negedge clk);
    e_rdy = '0; e_vld = '0; e_ist = 0; e_ost = 0;
    n_wait = m_wait; n_ich = m_ich; n_iel = m_iel; n_io = m_io;
    n_full = m_full; n_och = m_och; n_oblk = 0; n_word = m_word;
    s_bad = 0; s_ti = 0; s_to = 0;
    if (m_full) e_vld[m_och] = 1'b1;

    a = int'(addr_in);
    if (m_wait) begin
      if (ch_in_valid[m_ich]) begin
        e_rdy[m_ich] = 1'b1; n_io = ch_in_data[m_ich*W +: W]; n_wait = 0;
      end else if (TM > 0 && m_iel == TM) begin
        n_io = '0; s_ti = 1; n_wait = 0;
      end else begin
        e_ist = 1; n_iel = m_iel + 1;
      end
    end else if (req_in) begin
      if (a >= NIN) begin
        n_io = '0; s_bad = 1;
      end else if (ch_in_valid[a]) begin
        e_rdy[a] = 1'b1; n_io = ch_in_data[a*W +: W];
      end else begin
        e_ist = 1; n_wait = 1; n_ich = a; n_iel = 1;
      end
    end

    drain = m_full && ch_out_ready[m_och];
    if (drain) n_full = 0;
    if (out_en) begin
      a = int'(addr_out);
      if (a >= NOU) s_bad = 1;
      else if (!m_full || drain || (TM > 0 && m_oblk == TM)) begin
        s_to = m_full && !drain;
        n_full = 1; n_och = a; n_word = data_out;
      end else begin
        e_ost = 1; n_oblk = m_oblk + 1;
      end
    end

    obs_stall = stall; obs_rdy = ch_in_ready; obs_vld = ch_out_valid; obs_data = ch_out_data;
    chk("in_ready", ch_in_ready, e_rdy);
    chk("stall", stall, e_ist | e_ost);
    chk("out_valid", ch_out_valid, e_vld);
    chk("out_data", ch_out_data, m_word);
    chk("io_in", io_in, m_io);
    chk("tmo_in", tmo_in, m_ti);
    chk("tmo_out", tmo_out, m_to);
    chk("bad_addr", bad_addr, m_bad);
    m_stall = e_ist | e_ost;

    if (rst) begin
      m_wait = 0; m_ich = 0; m_iel = 0; m_io = '0; m_full = 0; m_och = 0;
      m_oblk = 0; m_word = '0; m_ti = 0; m_to = 0; m_bad = 0;
    end else begin
      m_wait = n_wait; m_ich = n_ich; m_iel = n_iel; m_io = n_io;
      m_full = n_full; m_och = n_och; m_oblk = n_oblk; m_word = n_word;
      m_ti  = s_ti  | (m_ti  & !err_clr);
      m_to  = s_to  | (m_to  & !err_clr);
      m_bad = s_bad | (m_bad & !err_clr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; req_in = 0; addr_in = '0; out_en = 0; addr_out = '0; data_out = '0;
    err_clr = 0; ch_in_valid = '0; ch_out_ready = '1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst, npulse;
    idle();
    ch_in_data = '0;
    rst = 1;
    step(); step();
    rst = 0;
    step();
    chk("rst_stall", obs_stall, 0);
    chk("rst_io_in", io_in, 0);
    chk("rst_vld", obs_vld, 0);

    // immediate input on channel 3
    ch_in_data[3*W +: W] = 32'h1234_5678;
    ch_in_valid = 6'h08; req_in = 1; addr_in = 3;
    step();
    chk("imm_ready", obs_rdy, 6'h08);
    chk("imm_stall", obs_stall, 0);
    chk("imm_io_in", io_in, 32'h1234_5678);
    idle(); step();

    // late input on channel 5
    req_in = 1; addr_in = 5; nst = 0; npulse = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin ch_in_valid = 6'h20; ch_in_data[5*W +: W] = 32'hCAFE_0005; end
      step();
      nst += int'(obs_stall);
      if (obs_rdy == 6'h20) npulse++;
      if (obs_rdy != 0) break;
    end
    idle();
    chk("late_stall_cycles", nst, 4);
    chk("late_ready_pulses", npulse, 1);
    chk("late_io_in", io_in, 32'hCAFE_0005);
    step();

    // input timeout on channel 2
    req_in = 1; addr_in = 2; nst = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nst += int'(obs_stall);
      if (!obs_stall) break;
    end
    idle();
    chk("itmo_stall_cycles", nst, TM);
    chk("itmo_flag", tmo_in, 1);
    chk("itmo_io_in", io_in, 0);
    err_clr = 1; step(); err_clr = 0;
    chk("itmo_clr", tmo_in, 0);

    // output back-to-back
    ch_out_ready = '0; out_en = 1; addr_out = 1; data_out = 32'hAAAA;
    step();
    chk("b2b_stall0", obs_stall, 0);
    addr_out = 6; data_out = 32'h5555; ch_out_ready = 7'h02;
    step();
    chk("b2b_vld1", obs_vld, 7'h02);
    chk("b2b_data1", obs_data, 32'hAAAA);
    chk("b2b_stall1", obs_stall, 0);
    out_en = 0; ch_out_ready = '0;
    step();
    chk("b2b_vld2", obs_vld, 7'h40);
    chk("b2b_data2", obs_data, 32'h5555);
    idle(); step();

    // output blocked 7 cycles on channel 4
    ch_out_ready = '0; out_en = 1; addr_out = 4; data_out = 32'h0000_00A4;
    step();
    addr_out = 2; data_out = 32'h0000_00B2; nst = 0;
    for (int i = 0; i < 7; i++) begin step(); nst += int'(obs_stall); end
    ch_out_ready = 7'h10;
    step();
    chk("blk_drain_stall", obs_stall, 0);
    out_en = 0; ch_out_ready = '0;
    step();
    chk("blk_stall_cycles", nst, 7);
    chk("blk_vld", obs_vld, 7'h04);
    chk("blk_data", obs_data, 32'h0000_00B2);
    idle(); step();

    // output timeout
    ch_out_ready = '0; out_en = 1; addr_out = 4; data_out = 32'h0000_0C04;
    step();
    addr_out = 2; data_out = 32'h0000_0D02; nst = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nst += int'(obs_stall);
      if (!obs_stall) break;
    end
    out_en = 0;
    chk("otmo_stall_cycles", nst, TM);
    chk("otmo_flag", tmo_out, 1);
    step();
    chk("otmo_vld", obs_vld, 7'h04);
    chk("otmo_data", obs_data, 32'h0000_0D02);
    idle(); step();

    // reset during WAIT_IN
    ch_in_data[0 +: W] = 32'hDEAD_BEEF; ch_in_valid = 6'h01; req_in = 1; addr_in = 0;
    step();
    ch_in_valid = '0; addr_in = 1;
    step(); step();
    chk("rstw_stall_before", obs_stall, 1);
    rst = 1; req_in = 0;
    step();
    rst = 0;
    step();
    chk("rstw_stall", obs_stall, 0);
    chk("rstw_ready", obs_rdy, 0);
    chk("rstw_io_in", io_in, 0);
    chk("rstw_tmo_out", tmo_out, 0);

    // out-of-range channels
    ch_in_valid = 6'h01; req_in = 1; addr_in = 0;
    step();
    addr_in = 7; ch_in_valid = '1;
    step();
    chk("bad_in_stall", obs_stall, 0);
    chk("bad_in_ready", obs_rdy, 0);
    idle();
    chk("bad_in_flag", bad_addr, 1);
    chk("bad_in_io_in", io_in, 0);
    err_clr = 1; step(); err_clr = 0;
    chk("bad_clr", bad_addr, 0);
    out_en = 1; addr_out = 7; data_out = 32'h7777;
    step();
    chk("bad_out_stall", obs_stall, 0);
    out_en = 0;
    chk("bad_out_flag", bad_addr, 1);
    step();
    chk("bad_out_vld", obs_vld, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) begin
        req_in   = ($urandom_range(0, 2) == 0);
        addr_in  = 3'($urandom_range(0, 7));
        out_en   = ($urandom_range(0, 2) == 0);
        addr_out = 3'($urandom_range(0, 7));
        data_out = $urandom;
      end
      for (int k = 0; k < NIN; k++) begin
        ch_in_valid[k] = ($urandom_range(0, 7) == 0);
        ch_in_data[k*W +: W] = $urandom;
      end
      for (int k = 0; k < NOU; k++) ch_out_ready[k] = ($urandom_range(0, 5) == 0);
      err_clr = ($urandom_range(0, 30) == 0);
      rst     = ($urandom_range(0, 400) == 0);
      step();
    end
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
